// File: rtl/vc_pkg.sv
// Shared definitions for the victim-cache requester and VC control:
// requester state encoding, line geometry and address alignment.
package vc_pkg;

    localparam int VC_S_OFFSET = 5;
    localparam int VC_S_LINE   = 8 * (2 ** VC_S_OFFSET);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_PROBE_RESP,
        ST_VWR,
        ST_VWAIT,
        ST_MEM,
        ST_FILL
    } vc_req_state_t;

    // Clears the byte-offset bits so the address names a whole line.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int s_offset);
        logic [31:0] mask;
        mask = (32'd1 << s_offset) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/vc_wr_watchdog.sv
// Cycle counter bounding the wait for a VC write acknowledge.
// Counts while enabled, stops at TIMEOUT and reports expiry there.
module vc_wr_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    assign expired = (cnt_q == W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/vc_requester.sv
// L1-side initiator of the victim-cache protocol: probes the VC on a miss,
// inserts the evicted line, falls back to memory and returns the fill line.
module vc_requester
    import vc_pkg::*;
#(
    parameter int S_OFFSET   = VC_S_OFFSET,
    parameter int S_LINE     = 8 * (2 ** S_OFFSET),
    parameter int WR_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    output logic              miss_ready,
    input  logic [31:0]       miss_addr,
    input  logic              victim_valid,
    input  logic              victim_dirty,
    input  logic [31:0]       victim_addr,
    input  logic [S_LINE-1:0] victim_line,
    output logic              fill_valid,
    output logic [S_LINE-1:0] fill_line,
    output logic              fill_from_vc,
    output logic              vc_read,
    output logic              vc_write,
    output logic [31:0]       vc_address,
    output logic [S_LINE-1:0] vc_wdata,
    output logic              vc_wdata_dirty,
    input  logic              vc_rdata_exists,
    input  logic [S_LINE-1:0] vc_rdata,
    output logic              pmem_read,
    output logic [31:0]       pmem_address,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  vc_hits,
    output logic [CNT_W-1:0]  vc_misses,
    output logic              wr_err,
    output vc_req_state_t     dbg_state
);

    // Handshakes: the L1 side is valid/ready (miss_req accepted only while
    // miss_ready); VC requests are single-cycle pulses whose payload stays
    // stable until vc_rdata_exists answers (probe: exactly one cycle later);
    // pmem_read is a level held until the one-cycle pmem_resp.

    vc_req_state_t     state_q, state_d;
    logic [31:0]       miss_addr_q;
    logic              victim_valid_q;
    logic              victim_dirty_q;
    logic [31:0]       victim_addr_q;
    logic [S_LINE-1:0] victim_line_q;
    logic              hit_q;
    logic [S_LINE-1:0] line_q;
    logic [CNT_W-1:0]  hits_q;
    logic [CNT_W-1:0]  misses_q;
    logic              wr_err_q;
    logic              wd_expired;

    vc_wr_watchdog #(
        .TIMEOUT(WR_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_VWAIT),
        .enable (state_q == ST_VWAIT),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (miss_req) state_d = ST_PROBE;
            ST_PROBE:      state_d = ST_PROBE_RESP;
            ST_PROBE_RESP: begin
                if (victim_valid_q)       state_d = ST_VWR;
                else if (vc_rdata_exists) state_d = ST_FILL;
                else                      state_d = ST_MEM;
            end
            ST_VWR:        state_d = ST_VWAIT;
            ST_VWAIT:      if (vc_rdata_exists || wd_expired) state_d = hit_q ? ST_FILL : ST_MEM;
            ST_MEM:        if (pmem_resp) state_d = ST_FILL;
            ST_FILL:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr_q    <= '0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
            victim_addr_q  <= '0;
            victim_line_q  <= '0;
            hit_q          <= 1'b0;
            line_q         <= '0;
            hits_q         <= '0;
            misses_q       <= '0;
            wr_err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (miss_req) begin
                        miss_addr_q    <= miss_addr;
                        victim_valid_q <= victim_valid;
                        victim_dirty_q <= victim_dirty;
                        victim_addr_q  <= victim_addr;
                        victim_line_q  <= victim_line;
                        hit_q          <= 1'b0;
                    end
                end
                ST_PROBE_RESP: begin
                    if (vc_rdata_exists) begin
                        hit_q  <= 1'b1;
                        line_q <= vc_rdata;
                        if (hits_q != '1) hits_q <= hits_q + CNT_W'(1);
                    end else begin
                        if (misses_q != '1) misses_q <= misses_q + CNT_W'(1);
                    end
                end
                ST_VWAIT: begin
                    // A late ack on the expiry cycle still counts as an ack.
                    if (wd_expired && !vc_rdata_exists) wr_err_q <= 1'b1;
                end
                ST_MEM: begin
                    if (pmem_resp) line_q <= pmem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        miss_ready     = 1'b0;
        vc_read        = 1'b0;
        vc_write       = 1'b0;
        vc_address     = '0;
        vc_wdata       = '0;
        vc_wdata_dirty = 1'b0;
        pmem_read      = 1'b0;
        pmem_address   = '0;
        fill_valid     = 1'b0;
        fill_line      = '0;
        fill_from_vc   = 1'b0;
        unique case (state_q)
            ST_IDLE:  miss_ready = 1'b1;
            ST_PROBE: begin
                vc_read    = 1'b1;
                vc_address = line_align(miss_addr_q, S_OFFSET);
            end
            ST_VWR, ST_VWAIT: begin
                vc_write       = (state_q == ST_VWR);
                vc_address     = line_align(victim_addr_q, S_OFFSET);
                vc_wdata       = victim_line_q;
                vc_wdata_dirty = victim_dirty_q;
            end
            ST_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = line_align(miss_addr_q, S_OFFSET);
            end
            ST_FILL: begin
                fill_valid   = 1'b1;
                fill_line    = line_q;
                fill_from_vc = hit_q;
            end
            default: ;
        endcase
    end

    assign vc_hits   = hits_q;
    assign vc_misses = misses_q;
    assign wr_err    = wr_err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/vc_requester.md
# vc_requester

L1-side initiator for the victim-cache request/response protocol. On an L1 miss it probes the victim cache (VC) for the missing line and writes the L1's evicted line into the VC. If the VC misses, it fetches the line from physical memory, then returns the fill line to the L1. It sits between the L1 cache controller and both the VC control/datapath and the memory port, and it owns the issue-pulse / hold-payload side of the VC handshake.

## Interface
- S_OFFSET, 5, byte-offset bits per line
- S_LINE, 256, line width in bits (8·2^S_OFFSET)
- WR_TIMEOUT, 64, cycles to wait for VC write acknowledge before flagging an error
- CNT_W, 32, width of hit/miss statistics counters
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock is clk
- miss_req  in  1  L1 miss request
- miss_ready  out  1  requester idle, can accept a request
- miss_addr  in  32  missing address (byte address)
- victim_valid  in  1  L1 is evicting a line with this miss
- victim_dirty  in  1  evicted line is dirty
- victim_addr  in  32  evicted line address
- victim_line  in  S_LINE  evicted line data
- fill_valid  out  1  one-cycle pulse: fill_line valid
- fill_line  out  S_LINE  line returned to the L1
- fill_from_vc  out  1  qualifies fill_valid: 1 = VC hit, 0 = memory
- vc_read  out  1  VC probe request pulse
- vc_write  out  1  VC insert request pulse
- vc_address  out  32  VC address, line-aligned (low S_OFFSET bits zero)
- vc_wdata  out  S_LINE  line to insert
- vc_wdata_dirty  out  1  dirty bit of the inserted line
- vc_rdata_exists  in  1  VC response: read hit, or write complete
- vc_rdata  in  S_LINE  VC read data
- pmem_read  out  1  memory read request, level
- pmem_address  out  32  memory line address, line-aligned
- pmem_rdata  in  S_LINE  memory line data
- pmem_resp  in  1  memory response, one cycle
- vc_hits, vc_misses  out  CNT_W  saturating statistics counters
- wr_err  out  1  sticky: VC write timed out

## Operation
- States: IDLE, PROBE, PROBE_RESP, VWR, VWAIT, MEM, FILL.
- IDLE: miss_ready=1. When miss_req=1, latch miss_addr, victim_* into registers, then go to PROBE.
- PROBE: vc_read=1 for exactly this cycle; vc_address = latched miss_addr line-aligned. Go to PROBE_RESP.
- PROBE_RESP: sample vc_rdata_exists.
  - If 1: set hit flag, capture vc_rdata into the line buffer, increment vc_hits.
  - Else: increment vc_misses.
  - Next state: VWR if victim_valid, else FILL if hit, else MEM.
- VWR: vc_write=1 for exactly this cycle; vc_address = victim_addr line-aligned; vc_wdata = victim_line; vc_wdata_dirty = victim_dirty. Go to VWAIT.
- VWAIT: vc_write=0; vc_address, vc_wdata and vc_wdata_dirty held stable. Wait for vc_rdata_exists=1, then go to FILL if hit, else MEM.
  - A watchdog counts cycles in VWAIT. On reaching WR_TIMEOUT: set wr_err and proceed as if acknowledged.
- MEM: pmem_read=1 held; pmem_address = miss line address. On pmem_resp=1, capture pmem_rdata and go to FILL.
- FILL: fill_valid=1; fill_line = buffer; fill_from_vc = hit flag. Go to IDLE.
- miss_req outside IDLE is ignored (miss_ready=0); the L1 must hold it.
- A miss request with vc_rdata_exists spuriously high in IDLE: the response is ignored, since it is only sampled in PROBE_RESP/VWAIT.
- The counters saturate at all-ones and do not wrap.

## Timing
- Reset: state IDLE.
  - miss_ready=1.
  - All request/valid outputs 0, addresses/data 0.
  - Counters 0, wr_err 0, watchdog 0.
- Reset mid-operation aborts the transaction; no fill is issued.
- Latency from accept (cycle n, handshake) to fill_valid:
  - VC hit, no victim: n+3.
  - VC hit, victim, ack k cycles after VWR: n+5+k-1.
  - VC miss, no victim: memory latency + n+4.
- The VC must answer a probe exactly one cycle after vc_read.

## Structure
- Shared package vc_pkg holds:
  - the state enum vc_req_state_t;
  - line/offset width constants, shared with the VC control;
  - the line_align function.
- One sub-module, vc_wr_watchdog: a counter with clear/enable/expired, width $clog2(WR_TIMEOUT+1).

## Test plan
- VC hit, no victim: miss_addr=0x0000_1234, vc_rdata_exists=1 at PROBE_RESP, vc_rdata=0xA5…A5 -> vc_address=0x0000_1220, fill_valid at n+3, fill_line=0xA5…A5, fill_from_vc=1, vc_hits=1.
- VC miss, victim dirty: victim_addr=0x0000_4000, ack 2 cycles after VWR, pmem_resp after 5 cycles with data 0x3C…3C:
  - exactly one vc_write pulse, with vc_wdata_dirty=1 held through VWAIT;
  - pmem_address = line-aligned miss address;
  - fill_from_vc=0; vc_misses=1.
- Write timeout: vc_rdata_exists never asserted in VWAIT -> wr_err=1 after WR_TIMEOUT cycles, FSM proceeds to MEM/FILL, wr_err stays 1 until rst.
- Back-to-back misses with miss_req held high: second request accepted only on the cycle after FILL; miss_ready=0 throughout.
- Reset during MEM: rst for one cycle -> pmem_read=0, fill_valid never pulses, counters 0, miss_ready=1 on the next cycle.
- Saturation: preload vc_hits to all-ones (CNT_W=4 build) and perform a hit -> vc_hits stays 0xF.
